// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and a tag sideband.
// The result, zero and illegal flags are formed before stage 0; later stages only transport them.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1110;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0001;
    localparam logic [3:0] OP_PASSA = 4'b1010;
    localparam logic [3:0] OP_NAND  = 4'b0111;
    localparam logic [3:0] OP_XNOR  = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1100;
    localparam logic [3:0] OP_ANDN  = 4'b0100;
    localparam logic [3:0] OP_ORN   = 4'b1101;

    // Returns {illegal, result}; unknown opcodes yield a zero result with the flag set.
    function automatic logic [WIDTH:0] logic_op(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_AND:   r = {1'b0, a & b};
            OP_OR:    r = {1'b0, a | b};
            OP_XOR:   r = {1'b0, a ^ b};
            OP_NOR:   r = {1'b0, ~(a | b)};
            OP_PASSA: r = {1'b0, a};
            OP_NAND:  r = {1'b0, ~(a & b)};
            OP_XNOR:  r = {1'b0, ~(a ^ b)};
            OP_PASSB: r = {1'b0, b};
            OP_ANDN:  r = {1'b0, a & ~b};
            OP_ORN:   r = {1'b0, a | ~b};
            default:  r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0]  alu_result_s;
    logic              alu_illegal_s;
    logic              alu_zero_s;

    logic [STAGES-1:0] ld_s;
    logic [STAGES-1:0] nxt_valid_s;
    logic [STAGES-1:0] nxt_zero_s;
    logic [STAGES-1:0] nxt_illegal_s;
    logic [WIDTH-1:0]  nxt_data_s [STAGES];
    logic [TAG_W-1:0]  nxt_tag_s  [STAGES];

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] zero_r;
    logic [STAGES-1:0] illegal_r;
    logic [WIDTH-1:0]  data_r [STAGES];
    logic [TAG_W-1:0]  tag_r  [STAGES];

    // Operation and flag generation ahead of stage 0.
    always_comb begin
        {alu_illegal_s, alu_result_s} = logic_op(ctrl, A, B);
        alu_zero_s = ~|alu_result_s;
    end

    // Load enables ripple back from the output so empty stages fill even while the tail is stalled.
    always_comb begin
        ld_s = '0;
        ld_s[STAGES-1] = ~valid_r[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            ld_s[k] = ld_s[k+1] | ~valid_r[k];
        end
    end

    // Value each stage captures when it loads; bubbles carry all-zero payload so dout reads 0 when idle.
    always_comb begin
        nxt_valid_s   = '0;
        nxt_zero_s    = '0;
        nxt_illegal_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            nxt_data_s[k] = '0;
            nxt_tag_s[k]  = '0;
        end
        if (in_valid) begin
            nxt_valid_s[0]   = 1'b1;
            nxt_zero_s[0]    = alu_zero_s;
            nxt_illegal_s[0] = alu_illegal_s;
            nxt_data_s[0]    = alu_result_s;
            nxt_tag_s[0]     = in_tag;
        end else begin
            nxt_valid_s[0]   = 1'b0;
        end
        for (int k = 1; k < STAGES; k++) begin
            nxt_valid_s[k]   = valid_r[k-1];
            nxt_zero_s[k]    = zero_r[k-1];
            nxt_illegal_s[k] = illegal_r[k-1];
            nxt_data_s[k]    = data_r[k-1];
            nxt_tag_s[k]     = tag_r[k-1];
        end
    end

    // Stage registers: reset flushes everything, otherwise a loading stage takes its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= '0;
            zero_r    <= '0;
            illegal_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= '0;
                tag_r[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    valid_r[k]   <= nxt_valid_s[k];
                    zero_r[k]    <= nxt_zero_s[k];
                    illegal_r[k] <= nxt_illegal_s[k];
                    data_r[k]    <= nxt_data_s[k];
                    tag_r[k]     <= nxt_tag_s[k];
                end
            end
        end
    end

    assign in_ready  = ld_s[0];
    assign out_valid = valid_r[STAGES-1];
    assign dout      = data_r[STAGES-1];
    assign zero      = zero_r[STAGES-1];
    assign illegal   = illegal_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: main instance WIDTH=32/STAGES=2,
// plus WIDTH=8 instances at STAGES=1 and STAGES=4 for latency coverage.
module tb_logic_unit_pipe;

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        il;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [3:0]  ctrl, in_tag, out_tag;
    logic [31:0] a, b, dout;

    logic        s_valid;
    logic [3:0]  s_ctrl, s_tag;
    logic [7:0]  s_a, s_b;
    logic        s_rdy;
    logic        s1_in_ready, s1_out_valid, s1_zero, s1_illegal;
    logic [7:0]  s1_dout;
    logic [3:0]  s1_tag;
    logic        s4_in_ready, s4_out_valid, s4_zero, s4_illegal;
    logic [7:0]  s4_dout;
    logic [3:0]  s4_tag;

    logic_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctrl(ctrl),
        .A(a), .B(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .zero(zero), .illegal(illegal), .out_tag(out_tag)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s1_in_ready), .ctrl(s_ctrl),
        .A(s_a), .B(s_b), .in_tag(s_tag), .out_valid(s1_out_valid), .out_ready(s_rdy),
        .dout(s1_dout), .zero(s1_zero), .illegal(s1_illegal), .out_tag(s1_tag)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(4), .TAG_W(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s4_in_ready), .ctrl(s_ctrl),
        .A(s_a), .B(s_b), .in_tag(s_tag), .out_valid(s4_out_valid), .out_ready(s_rdy),
        .dout(s4_dout), .zero(s4_zero), .illegal(s4_illegal), .out_tag(s4_tag)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit lat_mode = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q4[$];

    logic [3:0]  ops [10] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b1010,
                              4'b0111, 4'b1001, 4'b1100, 4'b0100, 4'b1101};
    logic [31:0] res [10] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000, 32'hF0F0_00FF,
                              32'hFF0F_FFF0, 32'h00FF_F00F, 32'h0FF0_0F0F, 32'hF000_00F0, 32'hF0FF_F0FF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Each legal opcode is a 2-input truth table indexed by {a,b}; the pass ops are the exception.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                   input logic [3:0] t, input int w);
        exp_t m;
        logic [3:0] tt;
        m.d = 32'd0; m.il = 1'b0; m.tag = t; m.cyc = 0; m.lat = 1'b0;
        case (op)
            4'b1010: tt = 4'b1100;
            4'b1100: tt = 4'b1010;
            4'b1000, 4'b1110, 4'b0110, 4'b0001, 4'b0111, 4'b1001, 4'b0100, 4'b1101: tt = op;
            default: begin tt = 4'b0000; m.il = 1'b1; end
        endcase
        for (int i = 0; i < w; i++) m.d[i] = tt[{av[i], bv[i]}];
        m.z = (m.d == 32'd0);
        return m;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input logic [31:0] d, input logic z,
                       input logic il, input logic [3:0] t, input int lat);
        check({nm, "_dout"}, d, e.d);
        check({nm, "_zero"}, {31'd0, z}, {31'd0, e.z});
        check({nm, "_illegal"}, {31'd0, il}, {31'd0, e.il});
        check({nm, "_tag"}, {28'd0, t}, {28'd0, e.tag});
        if (e.lat) check({nm, "_latency"}, cyc - e.cyc, lat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Main scoreboard monitor: pushes on input transfers, pops on output transfers.
    initial begin
        exp_t e;
        logic [31:0] hold_d;
        logic [3:0]  hold_t;
        bit stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                stalled = 1'b0;
            end else begin
                if (!out_valid) check("idle_dout", dout, 32'd0);
                if (stalled) begin
                    check("stall_hold_dout", dout, hold_d);
                    check("stall_hold_tag", {28'd0, out_tag}, {28'd0, hold_t});
                end
                if (out_valid && out_ready) begin
                    if (q0.size() == 0) check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                    else begin
                        e = q0.pop_front();
                        cmp("w32", e, dout, zero, illegal, out_tag, 2);
                    end
                end
                stalled = out_valid && !out_ready;
                hold_d  = dout;
                hold_t  = out_tag;
                if (in_valid && in_ready) begin
                    e = model(ctrl, a, b, in_tag, 32);
                    e.cyc = cyc;
                    e.lat = lat_mode;
                    q0.push_back(e);
                end
            end
        end
    end

    // Monitor for the narrow instances; out_ready is held high so latency is always STAGES.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q1.delete();
                q4.delete();
            end else begin
                if (s1_out_valid) begin
                    if (q1.size() == 0) check("s1_spurious", {31'd0, s1_out_valid}, 32'd0);
                    else begin
                        e = q1.pop_front();
                        cmp("s1", e, {24'd0, s1_dout}, s1_zero, s1_illegal, s1_tag, 1);
                    end
                end
                if (s4_out_valid) begin
                    if (q4.size() == 0) check("s4_spurious", {31'd0, s4_out_valid}, 32'd0);
                    else begin
                        e = q4.pop_front();
                        cmp("s4", e, {24'd0, s4_dout}, s4_zero, s4_illegal, s4_tag, 4);
                    end
                end
                if (s_valid) begin
                    check("s1_in_ready", {31'd0, s1_in_ready}, 32'd1);
                    check("s4_in_ready", {31'd0, s4_in_ready}, 32'd1);
                    e = model(s_ctrl, {24'd0, s_a}, {24'd0, s_b}, s_tag, 8);
                    e.cyc = cyc;
                    e.lat = 1'b1;
                    q1.push_back(e);
                    q4.push_back(e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        rst = 1'b1; in_valid = 1'b0; ctrl = 4'd0; a = 32'd0; b = 32'd0; in_tag = 4'd0; out_ready = 1'b1;
        s_valid = 1'b0; s_ctrl = 4'd0; s_a = 8'd0; s_b = 8'd0; s_tag = 4'd0; s_rdy = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming all ten ops back-to-back; each result shows one edge after its accept edge.
        lat_mode = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                in_valid = 1'b1; ctrl = ops[i]; a = 32'hF0F0_00FF; b = 32'h0FF0_0F0F; in_tag = 4'(i);
            end else in_valid = 1'b0;
            step();
            if (i >= 1) begin
                check("stream_valid", {31'd0, out_valid}, 32'd1);
                check("stream_dout", dout, res[i-1]);
                check("stream_tag", {28'd0, out_tag}, 32'(i - 1));
            end
        end

        in_valid = 1'b1; ctrl = 4'b0011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_tag = 4'd5;
        step();
        ctrl = 4'b1000; in_tag = 4'd6;
        step();
        check("illegal_dout", dout, 32'd0);
        check("illegal_zero", {31'd0, zero}, 32'd1);
        check("illegal_flag", {31'd0, illegal}, 32'd1);
        check("illegal_tag", {28'd0, out_tag}, 32'd5);
        ctrl = 4'b0110; a = 32'h1234_5678; b = 32'h1234_5678; in_tag = 4'd7;
        step();
        check("legal_after_illegal", {31'd0, illegal}, 32'd0);
        check("and_ones_dout", dout, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        step();
        check("xor_zero_dout", dout, 32'd0);
        check("xor_zero_flag", {31'd0, zero}, 32'd1);
        check("xor_zero_illegal", {31'd0, illegal}, 32'd0);
        step();
        step();
        lat_mode = 1'b0;

        // Backpressure: two ops fill the pipe, the third waits for a single released cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; ctrl = 4'b1110; a = $urandom; b = $urandom; in_tag = 4'd1;
        e1 = model(ctrl, a, b, in_tag, 32);
        step();
        ctrl = 4'b0100; a = $urandom; b = $urandom; in_tag = 4'd2;
        step();
        ctrl = 4'b1001; a = $urandom; b = $urandom; in_tag = 4'd3;
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("bp_out_tag", {28'd0, out_tag}, 32'd1);
        check("bp_dout", dout, e1.d);
        repeat (3) begin
            step();
            check("bp_dout_held", dout, e1.d);
            check("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("bp_next_tag", {28'd0, out_tag}, 32'd2);
        check("bp_refull", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_tag3", {28'd0, out_tag}, 32'd3);
        step();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Bubble collapse: idle cycle between two ops while stalled, both slots must be used.
        out_ready = 1'b0;
        in_valid = 1'b1; ctrl = 4'b0001; a = $urandom; b = $urandom; in_tag = 4'd8;
        step();
        in_valid = 1'b0;
        step();
        check("bub_tag8", {28'd0, out_tag}, 32'd8);
        check("bub_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; ctrl = 4'b0111; a = $urandom; b = $urandom; in_tag = 4'd9;
        step();
        in_valid = 1'b0;
        check("bub_full", {31'd0, in_ready}, 32'd0);
        check("bub_head", {28'd0, out_tag}, 32'd8);
        out_ready = 1'b1;
        step();
        check("bub_tag9_valid", {31'd0, out_valid}, 32'd1);
        check("bub_tag9", {28'd0, out_tag}, 32'd9);
        step();
        check("bub_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two ops in flight: neither may ever emerge.
        out_ready = 1'b0;
        in_valid = 1'b1; ctrl = 4'b1000; a = $urandom; b = $urandom; in_tag = 4'd10;
        step();
        in_tag = 4'd11;
        step();
        in_valid = 1'b0;
        check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_dout", dout, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) begin
            step();
            check("flush_no_delivery", {31'd0, out_valid}, 32'd0);
        end

        // Randomised traffic with random backpressure and illegal opcodes.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            ctrl = 4'($urandom); a = $urandom; b = $urandom; in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && q0.size() != 0; k++) step();
        check("w32_drain", q0.size(), 32'd0);

        // Narrow instances: the fixed op stream, then random traffic.
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_ctrl = ops[i]; s_a = 8'hFF; s_b = 8'h0F; s_tag = 4'(i);
            step();
        end
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_ctrl = 4'($urandom); s_a = 8'($urandom); s_b = 8'($urandom); s_tag = 4'($urandom);
            step();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 10 && (q1.size() != 0 || q4.size() != 0); k++) step();
        check("s1_drain", q1.size(), 32'd0);
        check("s4_drain", q4.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
